dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single 64-bit data memory between the processor load/store port (port 0) and a memory loader/debug port (port 1). Grants one request per cycle with round-robin fairness, drives the memory's word address, write enable, write data and byte mask, and routes each response back to the port that issued it. It sits between `processor`/loader and `mem_model`, replacing the direct processor-to-memory connection.

## Interface
- `ADDR_WIDTH`, 32: byte address width of requester ports.
- `DATA_WIDTH`, 64: data width; must be 64.
- `MASK_WIDTH`, 8: byte-mask width, equal to `DATA_WIDTH/8`.
- `RR_EN`, 1: 1 selects round-robin; 0 selects fixed priority, with port 0 winning.

- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port accept; a request transfers when valid and ready are both high.
- `req_we[1:0]`  in  2  1 = write, 0 = read.
- `req_addr0`, `req_addr1`  in  ADDR_WIDTH  byte address.
- `req_wdata0`, `req_wdata1`  in  64  write data.
- `req_wmask0`, `req_wmask1`  in  8  byte-lane write mask.
- `rsp_valid[1:0]`  out  2  per-port response strobe.
- `rsp_rdata`  out  64  read data shared by both ports; qualified by `rsp_valid`.
- `mem_addr`  out  ADDR_WIDTH-3  word address, equal to `req_addr[ADDR_WIDTH-1:3]` of the granted port.
- `mem_wr_en`  out  1  write strobe to memory.
- `mem_wdata`  out  64  write data to memory.
- `mem_wmask`  out  8  byte mask to memory.
- `mem_rdata`  in  64  memory read data, valid one cycle after the address is presented.
- `grant_cnt0`, `grant_cnt1`  out  16  saturating per-port grant counters.

## Operation
- **Arbitration:** combinational each cycle.
  - Only one port valid: that port is granted.
  - Both ports valid with `RR_EN=1`: the port opposite `last_grant` is granted.
  - Both ports valid with `RR_EN=0`: port 0 is granted.
  - `req_ready[i]` is 1 only for the granted port. A port that is not valid is never ready.
- **`last_grant` register:** updated to the granted index on every accepted transfer; holds otherwise. Reset value is 1, so port 0 wins the first tie.
- **Memory drive:** the `mem_*` outputs are driven combinationally from the granted port.
  - `mem_wr_en` = `req_we` of the granted port AND a grant being present.
  - With no grant: `mem_wr_en`=0, `mem_wmask`=0, `mem_addr` and `mem_wdata` hold the port 0 values.
- **Response tag:** registered as `{pend_valid, pend_port, pend_read}` on acceptance.
  - The next cycle, `rsp_valid[pend_port]`=1 for exactly one cycle.
  - `rsp_rdata` = `mem_rdata` if `pend_read`, else 0.
- **Writes:** each accepted write also produces a one-cycle `rsp_valid` acknowledge.
- **Address alignment:** address bits [2:0] are ignored; byte selection is by mask only. A write with mask 0 is accepted and acknowledged, and memory is unchanged.
- **Pipelining:** a new request may be accepted in the same cycle that the previous response is returned, giving full throughput of one transfer per cycle.
- **Grant counters:** increment on each accepted transfer for their port and saturate at 0xFFFF.

## Timing
- **Latency:** a request accepted at edge N produces `rsp_valid` high in the cycle between edges N and N+1; data is sampled by the requester at edge N+1.
- **Reset values:** `rsp_valid`=0, `pend_valid`=0, `last_grant`=1, both `grant_cnt*`=0. The combinational `mem_wr_en` is 0 whenever no request is valid.
- **Reset mid-operation:** an outstanding response is dropped and no `rsp_valid` is issued. Requesters must reissue.
- **Simultaneous requests:**
  - Under round-robin, continuous dual requests alternate 0,1,0,1 starting with port 0 after reset.
  - The loser's `req_ready` stays 0, and it must hold its request stable until accepted.
- **Back-to-back from one port:** that port is granted every cycle while the other port is idle.

## Structure
- **Shared package `dmem_pkg`:**
  - Constants `PORT_CPU`=0, `PORT_LDR`=1.
  - `DATA_WIDTH`, `MASK_WIDTH`.
  - Packed response-tag typedef `{valid, port, read}`.
- **Sub-module `rr_arb2`:** a two-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`, `rr_en`.
  - Outputs: one-hot `gnt[1:0]` and `gnt_idx`.
- **Top level:** the tag register, `last_grant` register, counters and mux logic stay in the top level.

## Test plan
- **Single read:** after reset, port 0 reads 0x10 where mem[2]=0xDEADBEEF_00000001. Required: `mem_addr`=2 that cycle; `rsp_valid`=2'b01 the next cycle with `rsp_rdata`=0xDEADBEEF_00000001.
- **Tie, round-robin:** both ports hold valid reads for 4 cycles with `RR_EN=1`. Required: grants 0,1,0,1; `rsp_valid` sequence 01,10,01,10; `grant_cnt0`=`grant_cnt1`=2.
- **Masked write then read:** port 1 writes 0x11223344_55667788 with mask 0x0F to address 0x18, then reads it back. Required: the low 4 bytes are updated, the upper bytes are unchanged, and the write ack appears on port 1 one cycle after acceptance.
- **Fixed priority:** `RR_EN=0`, both ports valid for 3 cycles. Required: port 0 is granted every cycle; `req_ready[1]` stays 0 until port 0 drops valid.
- **Reset mid-operation:** read accepted, then `nrst` is asserted before the next edge. Required: `rsp_valid`=0 immediately; counters=0; the first tie after release goes to port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and response-tag type for the data-memory arbiter.
package dmem_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;
   typedef struct packed {
      logic valid;
      logic port;
      logic read;
   } rsp_tag_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and memory-side signals of the shared data memory.
interface dmem_arbiter_if import dmem_pkg::*; #(parameter int ADDR_WIDTH = 32) ();
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] req_we;
   logic [ADDR_WIDTH-1:0] req_addr0;
   logic [ADDR_WIDTH-1:0] req_addr1;
   logic [DATA_WIDTH-1:0] req_wdata0;
   logic [DATA_WIDTH-1:0] req_wdata1;
   logic [MASK_WIDTH-1:0] req_wmask0;
   logic [MASK_WIDTH-1:0] req_wmask1;
   logic [1:0] rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic [ADDR_WIDTH-4:0] mem_addr;
   logic mem_wr_en;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [MASK_WIDTH-1:0] mem_wmask;
   logic [DATA_WIDTH-1:0] mem_rdata;
   modport slave (
      input req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
            req_wmask0, req_wmask1, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_wdata, mem_wmask
   );
   modport master (
      output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
             req_wmask0, req_wmask1, mem_rdata,
      input req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way picker, round-robin against last_grant or fixed priority to port 0.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       rr_en,
   output logic [1:0] gnt,
   output logic       gnt_idx
);
   always_comb begin
      gnt_idx = (req == 2'b11) ? (rr_en & ~last_grant) : (req[1] & ~req[0]);
      gnt = (|req) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 64-bit data memory between the CPU port and the loader port,
// one transfer per cycle, response routed back one cycle later.
module dmem_arbiter import dmem_pkg::*; #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MASK_WIDTH = 8,
   parameter bit RR_EN = 1'b1
) (
   input  logic               clk,
   input  logic               nrst,
   dmem_arbiter_if.slave      bus,
   output logic [15:0]        grant_cnt0,
   output logic [15:0]        grant_cnt1
);
   logic [1:0] gnt;
   logic gnt_idx;
   logic last_grant;
   logic xfer;
   rsp_tag_t pend;
   logic [DATA_WIDTH-1:0] wdata_sel;
   logic [MASK_WIDTH-1:0] wmask_sel;
   logic unused_addr_lsb;
   rr_arb2 u_arb (
      .req(bus.req_valid),
      .last_grant(last_grant),
      .rr_en(RR_EN),
      .gnt(gnt),
      .gnt_idx(gnt_idx)
   );
   // gnt_idx is 0 with no grant, so the idle bus shows port 0 address and data
   always_comb begin
      xfer = |gnt;
      wdata_sel = gnt_idx ? bus.req_wdata1 : bus.req_wdata0;
      wmask_sel = xfer ? (gnt_idx ? bus.req_wmask1 : bus.req_wmask0) : '0;
      bus.req_ready = gnt;
      bus.mem_addr = gnt_idx ? bus.req_addr1[ADDR_WIDTH-1:3] : bus.req_addr0[ADDR_WIDTH-1:3];
      bus.mem_wr_en = xfer & bus.req_we[gnt_idx];
      bus.mem_wdata = wdata_sel;
      bus.mem_wmask = wmask_sel;
      bus.rsp_valid = pend.valid ? (pend.port ? 2'b10 : 2'b01) : 2'b00;
      bus.rsp_rdata = pend.read ? bus.mem_rdata : '0;
      unused_addr_lsb = ^{bus.req_addr0[2:0], bus.req_addr1[2:0]};
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pend <= '0;
         last_grant <= PORT_LDR;
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         pend <= '{valid: xfer, port: gnt_idx, read: xfer & ~bus.req_we[gnt_idx]};
         if (xfer) last_grant <= gnt_idx;
         if (gnt[0] && ~&grant_cnt0) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (gnt[1] && ~&grant_cnt1) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a response scoreboard for round-robin and fixed-priority arbiters.
module tb_dmem_arbiter;
   import dmem_pkg::*;
   localparam logic [63:0] W2 = 64'hDEADBEEF_00000001;
   localparam logic [63:0] W3 = 64'hAAAAAAAA_BBBBBBBB;
   localparam logic [63:0] W4 = 64'h01234567_89ABCDEF;
   localparam logic [63:0] W3_NEW = 64'hAAAAAAAA_55667788;
   localparam logic [63:0] FP_DATA = 64'hC0FFEE00_12345678;
   typedef struct packed {
      logic [1:0]  port_oh;
      logic [63:0] data;
   } exp_t;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [15:0] rc0, rc1, fc0, fc1;
   logic [63:0] mem [0:15];
   exp_t q_rr[$];
   exp_t q_fp[$];
   exp_t e;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   dmem_arbiter_if #(.ADDR_WIDTH(32)) rr_if ();
   dmem_arbiter_if #(.ADDR_WIDTH(32)) fp_if ();
   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MASK_WIDTH(8), .RR_EN(1'b1)) u_rr (
      .clk(clk), .nrst(nrst), .bus(rr_if.slave), .grant_cnt0(rc0), .grant_cnt1(rc1));
   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MASK_WIDTH(8), .RR_EN(1'b0)) u_fp (
      .clk(clk), .nrst(nrst), .bus(fp_if.slave), .grant_cnt0(fc0), .grant_cnt1(fc1));
   assign fp_if.mem_rdata = FP_DATA;
   // memory model: contents reload while reset is held, reads return one cycle late
   always @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
         mem[2] <= W2;
         mem[3] <= W3;
         mem[4] <= W4;
      end else if (rr_if.mem_wr_en) begin
         for (int b = 0; b < 8; b++)
            if (rr_if.mem_wmask[b]) mem[rr_if.mem_addr[3:0]][b*8 +: 8] <= rr_if.mem_wdata[b*8 +: 8];
      end
      rr_if.mem_rdata <= mem[rr_if.mem_addr[3:0]];
   end
   always @(negedge clk) begin
      if (rr_if.rsp_valid != 2'b00) begin
         total++;
         if (q_rr.size() == 0) begin
            bad++;
            $display("FAIL rr_rsp_unexpected: rsp_valid=%b rdata=%h", rr_if.rsp_valid, rr_if.rsp_rdata);
         end else begin
            e = q_rr.pop_front();
            if (rr_if.rsp_valid !== e.port_oh || rr_if.rsp_rdata !== e.data) begin
               bad++;
               $display("FAIL rr_rsp: got=%b/%h want=%b/%h", rr_if.rsp_valid, rr_if.rsp_rdata, e.port_oh, e.data);
            end
         end
      end
      if (fp_if.rsp_valid != 2'b00) begin
         total++;
         if (q_fp.size() == 0) begin
            bad++;
            $display("FAIL fp_rsp_unexpected: rsp_valid=%b rdata=%h", fp_if.rsp_valid, fp_if.rsp_rdata);
         end else begin
            e = q_fp.pop_front();
            if (fp_if.rsp_valid !== e.port_oh || fp_if.rsp_rdata !== e.data) begin
               bad++;
               $display("FAIL fp_rsp: got=%b/%h want=%b/%h", fp_if.rsp_valid, fp_if.rsp_rdata, e.port_oh, e.data);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_rr();
      rr_if.req_valid = 2'b00;
      rr_if.req_we = 2'b00;
      rr_if.req_addr0 = '0;
      rr_if.req_addr1 = '0;
      rr_if.req_wdata0 = '0;
      rr_if.req_wdata1 = '0;
      rr_if.req_wmask0 = '0;
      rr_if.req_wmask1 = '0;
   endtask
   task automatic idle_fp();
      fp_if.req_valid = 2'b00;
      fp_if.req_we = 2'b00;
      fp_if.req_addr0 = '0;
      fp_if.req_addr1 = '0;
      fp_if.req_wdata0 = '0;
      fp_if.req_wdata1 = '0;
      fp_if.req_wmask0 = '0;
      fp_if.req_wmask1 = '0;
   endtask
   task automatic do_reset();
      nrst = 1'b0;
      idle_rr();
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
   endtask
   initial begin
      idle_rr();
      idle_fp();
      do_reset();
      @(negedge clk);
      chk("reset_rsp_valid", rr_if.rsp_valid, 2'b00);
      chk("reset_cnt0", rc0, 0);
      chk("reset_cnt1", rc1, 0);
      chk("reset_wr_en", rr_if.mem_wr_en, 0);
      // single read from port 0
      step();
      rr_if.req_valid = 2'b01;
      rr_if.req_addr0 = 32'h10;
      @(negedge clk);
      chk("rd_mem_addr", rr_if.mem_addr, 2);
      chk("rd_ready", rr_if.req_ready, 2'b01);
      chk("rd_wr_en", rr_if.mem_wr_en, 0);
      q_rr.push_back('{2'b01, W2});
      step();
      idle_rr();
      @(negedge clk);
      // round-robin tie from a fresh reset
      do_reset();
      rr_if.req_valid = 2'b11;
      rr_if.req_addr0 = 32'h10;
      rr_if.req_addr1 = 32'h20;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tie_ready", rr_if.req_ready, (i % 2) ? 2'b10 : 2'b01);
         q_rr.push_back((i % 2) ? exp_t'({2'b10, W4}) : exp_t'({2'b01, W2}));
         step();
      end
      idle_rr();
      @(negedge clk);
      chk("tie_cnt0", rc0, 2);
      chk("tie_cnt1", rc1, 2);
      // back-to-back from port 1, including an unaligned address
      step();
      rr_if.req_valid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         rr_if.req_addr1 = (i == 0) ? 32'h10 : (i == 1) ? 32'h20 : 32'h13;
         @(negedge clk);
         chk("b2b_ready", rr_if.req_ready, 2'b10);
         chk("b2b_addr", rr_if.mem_addr, (i == 1) ? 4 : 2);
         q_rr.push_back((i == 1) ? exp_t'({2'b10, W4}) : exp_t'({2'b10, W2}));
         step();
      end
      // masked write from port 1 then read back
      rr_if.req_we = 2'b10;
      rr_if.req_addr1 = 32'h18;
      rr_if.req_wdata1 = 64'h11223344_55667788;
      rr_if.req_wmask1 = 8'h0F;
      @(negedge clk);
      chk("wr_wr_en", rr_if.mem_wr_en, 1);
      chk("wr_wmask", rr_if.mem_wmask, 8'h0F);
      chk("wr_addr", rr_if.mem_addr, 3);
      chk("wr_wdata", rr_if.mem_wdata, 64'h11223344_55667788);
      q_rr.push_back('{2'b10, 64'h0});
      step();
      rr_if.req_we = 2'b00;
      rr_if.req_wmask1 = 8'h00;
      @(negedge clk);
      chk("rb_wr_en", rr_if.mem_wr_en, 0);
      q_rr.push_back('{2'b10, W3_NEW});
      step();
      // zero-mask write from port 0 leaves memory unchanged
      rr_if.req_valid = 2'b01;
      rr_if.req_we = 2'b01;
      rr_if.req_addr0 = 32'h1F;
      rr_if.req_wdata0 = '1;
      rr_if.req_wmask0 = 8'h00;
      @(negedge clk);
      chk("z_wr_en", rr_if.mem_wr_en, 1);
      chk("z_wmask", rr_if.mem_wmask, 0);
      q_rr.push_back('{2'b01, 64'h0});
      step();
      rr_if.req_we = 2'b00;
      rr_if.req_addr0 = 32'h18;
      @(negedge clk);
      q_rr.push_back('{2'b01, W3_NEW});
      step();
      // no grant: write strobe and mask forced low, port 0 address/data shown
      idle_rr();
      rr_if.req_we = 2'b11;
      rr_if.req_wmask0 = 8'hFF;
      rr_if.req_wmask1 = 8'hFF;
      rr_if.req_addr0 = 32'h28;
      rr_if.req_addr1 = 32'h30;
      rr_if.req_wdata0 = 64'h5555_0000_5555_0000;
      rr_if.req_wdata1 = 64'h6666_0000_6666_0000;
      @(negedge clk);
      chk("idle_wr_en", rr_if.mem_wr_en, 0);
      chk("idle_wmask", rr_if.mem_wmask, 0);
      chk("idle_addr", rr_if.mem_addr, 5);
      chk("idle_wdata", rr_if.mem_wdata, 64'h5555_0000_5555_0000);
      chk("idle_ready", rr_if.req_ready, 2'b00);
      step();
      idle_rr();
      // fixed priority on the second instance
      fp_if.req_valid = 2'b11;
      fp_if.req_addr0 = 32'h10;
      fp_if.req_addr1 = 32'h20;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fp_ready", fp_if.req_ready, 2'b01);
         q_fp.push_back('{2'b01, FP_DATA});
         step();
      end
      fp_if.req_valid = 2'b10;
      @(negedge clk);
      chk("fp_ready_p1", fp_if.req_ready, 2'b10);
      q_fp.push_back('{2'b10, FP_DATA});
      step();
      idle_fp();
      @(negedge clk);
      chk("fp_cnt0", fc0, 3);
      chk("fp_cnt1", fc1, 1);
      // reset while a read response is outstanding
      step();
      rr_if.req_valid = 2'b01;
      rr_if.req_addr0 = 32'h10;
      @(posedge clk);
      #1 nrst = 1'b0;
      idle_rr();
      #1;
      chk("mid_rst_rsp", rr_if.rsp_valid, 2'b00);
      chk("mid_rst_cnt0", rc0, 0);
      chk("mid_rst_cnt1", rc1, 0);
      step();
      nrst = 1'b1;
      rr_if.req_valid = 2'b11;
      rr_if.req_addr0 = 32'h10;
      rr_if.req_addr1 = 32'h20;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_rst_ready", rr_if.req_ready, i ? 2'b10 : 2'b01);
         q_rr.push_back(i ? exp_t'({2'b10, W4}) : exp_t'({2'b01, W2}));
         step();
      end
      idle_rr();
      repeat (2) @(negedge clk);
      chk("rr_queue_empty", q_rr.size(), 0);
      chk("fp_queue_empty", q_fp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
